dcache_wt: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache for the memory stage. Replaces the fixed 1 KiB single-cycle data array with a tag/valid/data line store in front of a backing memory reached over a req/ack handshake. Asserts `stall` to the pipeline while a miss fill or a write-through is outstanding. Provides saturating hit and miss counters for performance bring-up.

---
 rtl/dcache_wt.sv | 136 +++++++++++++
 tb/tb_dcache_wt.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache in front of a req/ack backing memory.
// Latency: load hit returns the next cycle; miss/store returns two cycles after the ack cycle.
// Backpressure: stall holds the pipeline from the miss/store cycle through the ack cycle.
module dcache_wt #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [63:0]          req_addr,
  input  logic [63:0]          req_wdata,
  output logic [63:0]          rd_data,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [63:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [63:0]          mem_rdata,
  output logic [CNT_BITS-1:0]  hit_cnt,
  output logic [CNT_BITS-1:0]  miss_cnt
);
  localparam int WORD_BITS = ADDR_BITS - 3;
  localparam int TAG_BITS  = WORD_BITS - INDEX_BITS;
  localparam int LINES     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WTHRU, RESP} state_t;
  state_t state_q, state_d;

  logic [WORD_BITS-1:0]  word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [63:0]           data_q [LINES];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  logic                  hit;
  logic                  ack;
  logic                  ld_hit;
  logic                  ld_miss;
  logic                  unused_addr_bits;

  // Byte-offset and out-of-range address bits carry no meaning here.
  assign unused_addr_bits = ^{req_addr[63:ADDR_BITS], req_addr[2:0]};

  assign word = req_addr[ADDR_BITS-1:3];
  assign idx  = word[INDEX_BITS-1:0];
  assign tag  = word[WORD_BITS-1:INDEX_BITS];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  // An ack only counts while a request is actually outstanding.
  assign ack  = mem_req && mem_ack;

  assign ld_hit  = (state_q == IDLE) && req_valid && !req_write && hit;
  assign ld_miss = (state_q == IDLE) && req_valid && !req_write && !hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: misses fill, stores write through, both finish via RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (req_valid && (req_write || !hit)) state_d = req_write ? WTHRU : FILL;
      FILL, WTHRU: if (ack) state_d = RESP;
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Pipeline stall: raised combinationally the moment a miss or store is seen.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:        stall = req_valid && (req_write || !hit);
      FILL, WTHRU: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  // Backing-memory request is launched on leaving IDLE and held until the ack edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if ((state_q == IDLE) && (state_d != IDLE)) begin
      mem_req   <= 1'b1;
      mem_we    <= req_write;
      mem_addr  <= {word, 3'b000};
      mem_wdata <= req_wdata;
    end else if (ack) begin
      mem_req   <= 1'b0;
    end
  end

  // Load result: hits update immediately, misses and stores update in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_data <= '0;
    else if (ld_hit)           rd_data <= data_q[idx];
    else if (state_q == RESP)  rd_data <= req_write ? req_wdata : data_q[idx];
  end

  // Valid bits: only a completed fill validates a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          valid_q      <= '0;
    else if ((state_q == FILL) && ack)   valid_q[idx] <= 1'b1;
  end

  // Line data and tags: fills replace the line, store hits patch it, store misses leave it.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && ack) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if ((state_q == WTHRU) && ack && hit) begin
      data_q[idx] <= req_wdata;
    end
  end

  // Saturating load hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ld_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_BITS'(1);
      if (ld_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Randomised plus directed bench for dcache_wt with a scoreboard-driven monitor.
// Reference: cache lines, backing memory and counters kept as plain arrays.
// Memory responder acks after a chosen number of request cycles.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [63:0] rd_data;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [3:0]  hit_cnt, miss_cnt;

  dcache_wt #(.ADDR_BITS(10), .INDEX_BITS(4), .CNT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(rd_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic [63:0] hits;
    logic [63:0] misses;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [63:0] mem_arr [128];
  bit          m_valid [16];
  int          m_tag   [16];
  logic [63:0] m_data  [16];
  int          m_hit, m_miss;

  // Responder control / expectations
  int          lat_next = 1;
  int          ack_count = 0;
  bit          stray_ack = 0;
  bit          exp_we;
  logic [9:0]  exp_addr;
  logic [63:0] exp_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_hit = 0;
    m_miss = 0;
  endtask

  // Backing memory: ack once the request has been up for lat_next cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = stray_ack;
      if (rst_n && mem_req) begin
        wait_cnt++;
        if (wait_cnt >= lat_next) begin
          mem_ack = 1;
          mem_rdata = mem_arr[mem_addr[9:3]];
          chk("mem_we", 64'(mem_we), 64'(exp_we));
          chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
          if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
          ack_count++;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: one cycle after a retiring edge, pop the expectation and compare.
  initial begin
    bit          ret;
    exp_t        e;
    logic [63:0] last_rd;
    ret = 0;
    last_rd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        ret = 0;
        last_rd = '0;
      end else if (ret) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty: retire seen with no expectation at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("rd_data", rd_data, e.rd);
          chk("hit_cnt", 64'(hit_cnt), e.hits);
          chk("miss_cnt", 64'(miss_cnt), e.misses);
          last_rd = e.rd;
        end
      end else begin
        chk("rd_hold", rd_data, last_rd);
      end
      ret = rst_n && req_valid && !stall;
    end
  end

  // Issue one request; predict from the reference, then wait for it to retire.
  task automatic do_req(input bit wr, input logic [6:0] w, input logic [63:0] wd, input int lat);
    int          idx, tg, stalls, acks0;
    bit          hit, need;
    logic [63:0] a;
    exp_t        e;
    idx = int'(w) % 16;
    tg  = int'(w) / 16;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    need = wr || !hit;
    if (wr) begin
      mem_arr[w] = wd;
      if (hit) m_data[idx] = wd;
      e.rd = wd;
    end else if (hit) begin
      e.rd = m_data[idx];
      if (m_hit < 15) m_hit++;
    end else begin
      m_valid[idx] = 1;
      m_tag[idx] = tg;
      m_data[idx] = mem_arr[w];
      e.rd = m_data[idx];
      if (m_miss < 15) m_miss++;
    end
    e.hits = 64'(m_hit);
    e.misses = 64'(m_miss);
    sbq.push_back(e);
    a = {$urandom, $urandom};
    a[9:3] = w;
    @(negedge clk);
    exp_we = wr;
    exp_addr = {w, 3'b000};
    exp_wdata = wd;
    lat_next = lat;
    acks0 = ack_count;
    req_valid = 1;
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    stalls = 0;
    #1;
    while (stall) begin
      stalls++;
      if (stalls > 100) begin
        $display("FAIL stall_timeout: request never retired at %0t", $time);
        $fatal(1);
      end
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 64'(stalls), need ? 64'(lat + 1) : 64'(0));
    chk("mem_acks", 64'(ack_count - acks0), 64'(need));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 0;
    req_write = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_rd_data", rd_data, 64'(0));
    chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    chk("rst_miss_cnt", 64'(miss_cnt), 64'(0));
    @(negedge clk);
    req_valid = 0;
    req_write = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  initial begin
    logic [6:0]  w;
    logic [63:0] wd;
    req_valid = 0;
    req_write = 0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 128; i++) mem_arr[i] = {$urandom, $urandom};
    mem_arr[8] = 64'h1122334455667788;
    model_clear();

    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_rd_data", rd_data, 64'(0));
    chk("reset_stall", 64'(stall), 64'(0));
    chk("reset_mem_req", 64'(mem_req), 64'(0));
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mem_wdata", mem_wdata, 64'(0));
    chk("reset_hit_cnt", 64'(hit_cnt), 64'(0));
    chk("reset_miss_cnt", 64'(miss_cnt), 64'(0));

    // Cold load 0x040 then repeat hit
    do_req(0, 7'h08, '0, 3);
    do_req(0, 7'h08, '0, 1);
    // Store hit then load back
    do_req(1, 7'h08, 64'hDEADBEEF00000001, 2);
    do_req(0, 7'h08, '0, 1);
    idle(2);
    // Store miss 0x100 then load must miss
    do_req(1, 7'h20, 64'h0123456789ABCDEF, 1);
    do_req(0, 7'h20, '0, 2);
    // Conflict on index 1
    do_req(0, 7'h01, '0, 1);
    do_req(0, 7'h11, '0, 4);
    do_req(0, 7'h01, '0, 2);
    idle(2);

    // Reset one cycle into a fill; stray ack afterwards is ignored
    @(negedge clk);
    lat_next = 50;
    req_valid = 1;
    req_write = 0;
    req_addr = 64'h1C0;
    @(posedge clk);
    #2;
    chk("fill_mem_req", 64'(mem_req), 64'(1));
    do_reset();
    @(negedge clk);
    #3 stray_ack = 1;
    @(negedge clk);
    #3 stray_ack = 0;
    @(negedge clk);
    #1;
    chk("stray_mem_req", 64'(mem_req), 64'(0));
    chk("stray_stall", 64'(stall), 64'(0));
    do_req(0, 7'h38, '0, 2);

    // Hit counter saturation
    do_req(0, 7'h05, '0, 1);
    for (int i = 0; i < 20; i++) do_req(0, 7'h05, '0, 1);
    idle(2);
    chk("hit_saturate", 64'(hit_cnt), 64'(15));

    // Randomised traffic with fresh counters
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 1) w = 7'($urandom_range(0, 127));
      else w = 7'($urandom_range(0, 1) * 16 + $urandom_range(0, 3));
      wd = {$urandom, $urandom};
      do_req($urandom_range(0, 9) < 3, w, wd, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("sb_drain", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
